// File: rtl/mips_ctrl_pkg.sv
// Purpose: shared constants for the mips multi-cycle controller: opcode/funct codes,
//          FSM state encoding, instruction classes and ALU/NPC/WA/WD select codes.
// Latency: n/a (declarations only).   Backpressure: n/a.
package mips_ctrl_pkg;

   // primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd4;
   localparam logic [2:0] ALU_SLL = 3'd5;
   localparam logic [2:0] ALU_LUI = 3'd6;

   // next-PC select
   localparam logic [1:0] NPC_PC4 = 2'd0;
   localparam logic [1:0] NPC_BR  = 2'd1;
   localparam logic [1:0] NPC_JMP = 2'd2;
   localparam logic [1:0] NPC_RS  = 2'd3;

   // register-file write address / write data selects
   localparam logic [1:0] WA_RT  = 2'd0;
   localparam logic [1:0] WA_RD  = 2'd1;
   localparam logic [1:0] WA_RA  = 2'd2;
   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_DM  = 2'd1;
   localparam logic [1:0] WD_PC  = 2'd2;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXE_R, S_EXE_I, S_ALU_WB, S_MEM_ADR,
      S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

   typedef enum logic [3:0] {
      C_ALU_R, C_ALU_I, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_ILL
   } iclass_t;

endpackage

// File: rtl/mips_ctrl_dec.sv
// Purpose: combinational decode of op/funct into instruction class, ALU op and ext op.
// Latency: 0 cycles (pure combinational).   Backpressure: none.
// Ports: i_op/i_funct from IR; o_cls class, o_alu_op ALU code, o_ext_op 1=sign-extend.
module mips_ctrl_dec
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   output iclass_t    o_cls,
   output logic [2:0] o_alu_op,
   output logic       o_ext_op
);

   always_comb begin
      o_cls    = C_ILL;
      o_alu_op = ALU_ADD;
      o_ext_op = 1'b0;
      case (i_op)
         OP_RTYPE: begin
            case (i_funct)
               FN_ADDU: begin o_cls = C_ALU_R; o_alu_op = ALU_ADD; end
               FN_SUBU: begin o_cls = C_ALU_R; o_alu_op = ALU_SUB; end
               FN_AND:  begin o_cls = C_ALU_R; o_alu_op = ALU_AND; end
               FN_OR:   begin o_cls = C_ALU_R; o_alu_op = ALU_OR;  end
               FN_SLT:  begin o_cls = C_ALU_R; o_alu_op = ALU_SLT; end
               FN_SLL:  begin o_cls = C_ALU_R; o_alu_op = ALU_SLL; end
               FN_JR:   o_cls = C_JR;
               default: o_cls = C_ILL;
            endcase
         end
         OP_ADDIU: begin o_cls = C_ALU_I; o_alu_op = ALU_ADD; o_ext_op = 1'b1; end
         OP_ORI:   begin o_cls = C_ALU_I; o_alu_op = ALU_OR;  end
         OP_LUI:   begin o_cls = C_ALU_I; o_alu_op = ALU_LUI; end
         OP_LW:    o_cls = C_LW;
         OP_SW:    o_cls = C_SW;
         OP_BEQ:   o_cls = C_BEQ;
         OP_J:     o_cls = C_J;
         OP_JAL:   o_cls = C_JAL;
         default:  o_cls = C_ILL;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Purpose: multi-cycle control FSM sequencing the mips datapath (PC, IR, RF, ALU, DM).
// Latency: beq/j/jal/jr 3, R/I-ALU/sw 4, lw 5 cycles (plus memory wait cycles).
// Backpressure: with MC_MEM_WAIT_EN defined, MEM_RD/MEM_WR hold until dmem_rdy=1.
// Ports: clk/rst (sync, active-high); op/funct from IR; zero from ALU; outputs are the
//   datapath write enables and mux selects, instr_done pulse, sticky illegal, state.
// Option macro: MC_MEM_WAIT_EN adds the dmem_rdy input; undefined = single-cycle memory.
module mips_mc_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W         = 3,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   output logic               pc_we,
   output logic [1:0]         npc_sel,
   output logic               ir_we,
   output logic               rf_we,
   output logic [1:0]         rf_wa_sel,
   output logic [1:0]         rf_wd_sel,
   output logic               ext_op,
   output logic               alu_srcb,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               dm_we,
   output logic               instr_done,
   output logic               illegal,
   output logic [3:0]         state
`ifdef MC_MEM_WAIT_EN
   ,
   input  logic               dmem_rdy
`endif
);

   state_t     r_state, w_next;
   iclass_t    w_cls;
   logic [2:0] w_dec_alu, w_alu_op;
   logic       w_dec_ext, w_mem_rdy;
   logic       w_pc_we, w_ir_we, w_rf_we, w_ext_op, w_alu_srcb, w_dm_we, w_done, w_illegal;
   logic [1:0] w_npc_sel, w_wa_sel, w_wd_sel;

`ifdef MC_MEM_WAIT_EN
   assign w_mem_rdy = dmem_rdy;
`else
   assign w_mem_rdy = 1'b1;
`endif

   // IR is loaded at the end of FETCH and stays stable for the rest of the
   // instruction, so the class can be decoded live in every later state.
   mips_ctrl_dec u_dec (
      .i_op     (op),
      .i_funct  (funct),
      .o_cls    (w_cls),
      .o_alu_op (w_dec_alu),
      .o_ext_op (w_dec_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_pc_we    = 1'b0;
      w_npc_sel  = NPC_PC4;
      w_ir_we    = 1'b0;
      w_rf_we    = 1'b0;
      w_wa_sel   = WA_RT;
      w_wd_sel   = WD_ALU;
      w_ext_op   = 1'b0;
      w_alu_srcb = 1'b0;
      w_alu_op   = ALU_ADD;
      w_dm_we    = 1'b0;
      w_done     = 1'b0;
      w_illegal  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_ir_we = 1'b1;
            w_pc_we = 1'b1;
            w_next  = S_DECODE;
         end
         S_DECODE: begin
            case (w_cls)
               C_ALU_R:       w_next = S_EXE_R;
               C_ALU_I:       w_next = S_EXE_I;
               C_LW, C_SW:    w_next = S_MEM_ADR;
               C_BEQ:         w_next = S_BRANCH;
               C_J, C_JAL, C_JR: w_next = S_JUMP;
               default: begin
                  if (TRAP_ON_ILLEGAL) begin
                     w_next = S_TRAP;
                  end else begin
                     // treated as a NOP that retires here
                     w_next = S_FETCH;
                     w_done = 1'b1;
                  end
               end
            endcase
         end
         S_EXE_R: begin
            w_alu_op = w_dec_alu;
            w_next   = S_ALU_WB;
         end
         S_EXE_I: begin
            w_alu_srcb = 1'b1;
            w_ext_op   = w_dec_ext;
            w_alu_op   = w_dec_alu;
            w_next     = S_ALU_WB;
         end
         S_ALU_WB: begin
            w_rf_we  = 1'b1;
            w_wa_sel = (w_cls == C_ALU_R) ? WA_RD : WA_RT;
            w_done   = 1'b1;
            w_next   = S_FETCH;
         end
         S_MEM_ADR: begin
            w_alu_srcb = 1'b1;
            w_ext_op   = 1'b1;
            w_next     = (w_cls == C_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            if (w_mem_rdy) w_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            w_rf_we  = 1'b1;
            w_wd_sel = WD_DM;
            w_done   = 1'b1;
            w_next   = S_FETCH;
         end
         S_MEM_WR: begin
            w_dm_we = 1'b1;
            if (w_mem_rdy) begin
               w_done = 1'b1;
               w_next = S_FETCH;
            end
         end
         S_BRANCH: begin
            w_alu_op  = ALU_SUB;
            w_npc_sel = NPC_BR;
            w_pc_we   = zero;     // the only Mealy output
            w_done    = 1'b1;
            w_next    = S_FETCH;
         end
         S_JUMP: begin
            w_pc_we = 1'b1;
            case (w_cls)
               C_JAL: begin
                  w_npc_sel = NPC_JMP;
                  w_rf_we   = 1'b1;
                  w_wa_sel  = WA_RA;
                  w_wd_sel  = WD_PC;
               end
               C_JR:    w_npc_sel = NPC_RS;
               default: w_npc_sel = NPC_JMP;
            endcase
            w_done = 1'b1;
            w_next = S_FETCH;
         end
         S_TRAP: begin
            w_illegal = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // reset overrides everything so an aborted instruction cannot write anything
   assign pc_we      = rst ? 1'b0 : w_pc_we;
   assign npc_sel    = rst ? 2'd0 : w_npc_sel;
   assign ir_we      = rst ? 1'b0 : w_ir_we;
   assign rf_we      = rst ? 1'b0 : w_rf_we;
   assign rf_wa_sel  = rst ? 2'd0 : w_wa_sel;
   assign rf_wd_sel  = rst ? 2'd0 : w_wd_sel;
   assign ext_op     = rst ? 1'b0 : w_ext_op;
   assign alu_srcb   = rst ? 1'b0 : w_alu_srcb;
   assign alu_op     = rst ? '0   : ALUOP_W'(w_alu_op);
   assign dm_we      = rst ? 1'b0 : w_dm_we;
   assign instr_done = rst ? 1'b0 : w_done;
   assign illegal    = rst ? 1'b0 : w_illegal;
   assign state      = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Purpose: randomized self-checking bench for mips_mc_ctrl against a per-instruction
//          expected-cycle-sequence model, plus directed latency / pc_we-count checks.
// Latency/backpressure: exercises dmem_rdy holds when MC_MEM_WAIT_EN is defined.
module tb_mips_mc_ctrl;
   import mips_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op, funct;
   logic       zero;
   logic       pc_we, ir_we, rf_we, ext_op, alu_srcb, dm_we, instr_done, illegal;
   logic [1:0] npc_sel, rf_wa_sel, rf_wd_sel;
   logic [2:0] alu_op;
   logic [3:0] state;
   logic       rdy;
`ifdef MC_MEM_WAIT_EN
   logic       dmem_rdy;
   assign dmem_rdy = rdy;
`endif

   mips_mc_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we), .rf_we(rf_we),
      .rf_wa_sel(rf_wa_sel), .rf_wd_sel(rf_wd_sel), .ext_op(ext_op),
      .alu_srcb(alu_srcb), .alu_op(alu_op), .dm_we(dm_we),
      .instr_done(instr_done), .illegal(illegal), .state(state)
`ifdef MC_MEM_WAIT_EN
      , .dmem_rdy(dmem_rdy)
`endif
   );

   always #5 clk = ~clk;

   // one expected cycle of an instruction
   typedef struct packed {
      logic       pc_we;
      logic [1:0] npc;
      logic       ir_we, rf_we;
      logic [1:0] wa, wd;
      logic       ext, srcb;
      logic [2:0] alu;
      logic       dm_we, done, ill;
      logic [3:0] st;
      logic       st_chk;
      logic       br;     // pc_we follows zero
      logic       hold;   // cycle repeats until memory ready
   } rec_t;

   rec_t seq[$];
   rec_t e;
   bit   chk_en = 1'b0;
   int   checks = 0, failures = 0;
   int   last_lat, last_pcw, last_dmw;

   task automatic check(input string nm, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("pc_we", pc_we, e.pc_we);
         check("npc_sel", npc_sel, e.npc);
         check("ir_we", ir_we, e.ir_we);
         check("rf_we", rf_we, e.rf_we);
         check("rf_wa_sel", rf_wa_sel, e.wa);
         check("rf_wd_sel", rf_wd_sel, e.wd);
         check("ext_op", ext_op, e.ext);
         check("alu_srcb", alu_srcb, e.srcb);
         check("alu_op", alu_op, e.alu);
         check("dm_we", dm_we, e.dm_we);
         check("instr_done", instr_done, e.done);
         check("illegal", illegal, e.ill);
         if (e.st_chk) check("state", state, e.st);
      end
   end

   function automatic rec_t mk(input state_t s);
      rec_t r;
      r = '0;
      r.st = s;
      r.st_chk = 1'b1;
      return r;
   endfunction

   // kinds: 0 addu 1 subu 2 and 3 or 4 slt 5 sll 6 addiu 7 ori 8 lui
   //        9 lw 10 sw 11 beq 12 j 13 jal 14 jr 15 illegal
   task automatic encode(input int k);
      funct = 6'($urandom);
      case (k)
         0: begin op = 6'h00; funct = 6'h21; end
         1: begin op = 6'h00; funct = 6'h23; end
         2: begin op = 6'h00; funct = 6'h24; end
         3: begin op = 6'h00; funct = 6'h25; end
         4: begin op = 6'h00; funct = 6'h2A; end
         5: begin op = 6'h00; funct = 6'h00; end
         6: op = 6'h09;
         7: op = 6'h0D;
         8: op = 6'h0F;
         9: op = 6'h23;
         10: op = 6'h2B;
         11: op = 6'h04;
         12: op = 6'h02;
         13: op = 6'h03;
         14: begin op = 6'h00; funct = 6'h08; end
         default: begin
            if ($urandom_range(1) == 0) op = 6'h3F;
            else begin op = 6'h00; funct = 6'h01; end
         end
      endcase
   endtask

   task automatic build(input int k);
      rec_t r;
      seq.delete();
      r = mk(S_FETCH); r.ir_we = 1; r.pc_we = 1; seq.push_back(r);
      seq.push_back(mk(S_DECODE));
      if (k <= 5) begin
         r = mk(S_EXE_R); r.alu = 3'(k); seq.push_back(r);   // addu..sll = ADD..SLL
         r = mk(S_ALU_WB); r.rf_we = 1; r.wa = 1; r.done = 1; seq.push_back(r);
      end else if (k <= 8) begin
         r = mk(S_EXE_I); r.srcb = 1; r.ext = (k == 6);
         r.alu = (k == 6) ? 3'd0 : (k == 7) ? 3'd3 : 3'd6;
         seq.push_back(r);
         r = mk(S_ALU_WB); r.rf_we = 1; r.wa = 0; r.done = 1; seq.push_back(r);
      end else if (k == 9 || k == 10) begin
         r = mk(S_MEM_ADR); r.srcb = 1; r.ext = 1; seq.push_back(r);
         if (k == 9) begin
            r = mk(S_MEM_RD); r.hold = 1; seq.push_back(r);
            r = mk(S_MEM_WB); r.rf_we = 1; r.wd = 1; r.done = 1; seq.push_back(r);
         end else begin
            r = mk(S_MEM_WR); r.dm_we = 1; r.hold = 1; r.done = 1; seq.push_back(r);
         end
      end else if (k == 11) begin
         r = mk(S_BRANCH); r.alu = 1; r.npc = 1; r.br = 1; r.done = 1; seq.push_back(r);
      end else if (k <= 14) begin
         r = mk(S_JUMP); r.pc_we = 1; r.done = 1;
         r.npc = (k == 14) ? 2'd3 : 2'd2;
         if (k == 13) begin r.rf_we = 1; r.wa = 2; r.wd = 2; end
         seq.push_back(r);
      end else begin
         for (int i = 0; i < 5; i++) begin
            r = mk(S_TRAP); r.ill = 1; seq.push_back(r);
         end
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int k = 0; k < n; k++) begin
         e = mk(S_FETCH);
         e.st_chk = (k > 0);
         chk_en = 1'b1;
         rdy = 1'($urandom);
         @(negedge clk);
         @(posedge clk); #1;
      end
      rst = 1'b0;
   endtask

   // zf: -1 random zero else forced; rdy_low: -1 random else forced low cycles;
   // abort_at: sequence index at which reset is applied (-1 none)
   task automatic run(input int k, input int zf, input int rdy_low, input int abort_at);
      rec_t r;
      int   cyc, wcnt;
      build(k);
      cyc = 0; last_lat = -1; last_pcw = 0; last_dmw = 0;
      for (int i = 0; i < seq.size(); i++) begin
         if (i == abort_at) begin
            do_reset(1 + $urandom_range(1));
            return;
         end
         if (i == 1) encode(k);
         r = seq[i];
         wcnt = 0;
         forever begin
            zero = (zf < 0) ? 1'($urandom) : 1'(zf);
`ifdef MC_MEM_WAIT_EN
            if (!r.hold)          rdy = 1'($urandom);
            else if (rdy_low >= 0) rdy = (wcnt >= rdy_low);
            else                   rdy = (wcnt >= 6) ? 1'b1 : 1'($urandom);
`else
            rdy = 1'b1;
`endif
            e = r;
            if (r.br) e.pc_we = zero;
            if (r.hold && !rdy) e.done = 1'b0;
            chk_en = 1'b1;
            @(negedge clk);
            cyc++;
            if (instr_done && last_lat < 0) last_lat = cyc;
            if (pc_we) last_pcw++;
            if (dm_we) last_dmw++;
            @(posedge clk); #1;
            wcnt++;
            if (!(r.hold && !rdy)) break;
         end
      end
   endtask

   initial begin
      int k, ab;
      rst = 1'b1; op = '0; funct = '0; zero = 1'b0; rdy = 1'b1;
      @(posedge clk); #1;
      do_reset(3);

      // directed: hand-computed latencies and PC-write counts
      run(0, -1, -1, -1);
      check("lat_addu", last_lat, 4);
      check("pcw_addu", last_pcw, 1);
      run(9, -1, 4, -1);
`ifdef MC_MEM_WAIT_EN
      check("lat_lw_wait", last_lat, 9);
`else
      check("lat_lw", last_lat, 5);
`endif
      run(10, -1, 0, -1);
      check("lat_sw", last_lat, 4);
      check("dmw_sw", last_dmw, 1);
      run(11, 1, -1, -1);
      check("lat_beq_taken", last_lat, 3);
      check("pcw_beq_taken", last_pcw, 2);
      run(11, 0, -1, -1);
      check("lat_beq_not", last_lat, 3);
      check("pcw_beq_not", last_pcw, 1);
      run(13, -1, -1, -1);
      check("lat_jal", last_lat, 3);
      check("pcw_jal", last_pcw, 2);
      run(14, -1, -1, -1);
      check("lat_jr", last_lat, 3);
      run(7, -1, -1, -1);
      check("lat_ori", last_lat, 4);
      run(15, -1, -1, -1);
      check("trap_no_done", last_lat, -1);
      do_reset(2);

      // randomized instruction stream with occasional resets mid-instruction
      for (int n = 0; n < 400; n++) begin
         k = ($urandom_range(19) == 0) ? 15 : $urandom_range(14);
         build(k);
         ab = ($urandom_range(11) == 0) ? $urandom_range(seq.size() - 1) : -1;
         run(k, -1, -1, ab);
         if (k == 15 && ab < 0) do_reset(2);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
